fft_frame_reorder: RTL and testbench

Parametrised streaming frame reorder buffer for the FFT datapath. It accepts frames of N = 2^LOG2N complex points, two points per cycle, using the team's `next`/`next_out` framing. It emits each frame in either natural or bit-reversed index order, selected per frame. The buffer is ping-pong, so back-to-back frames sustain full throughput. This block replaces the fixed-size, fixed-mode permutation stages at the FFT input and output boundaries, and adds overrun detection.

---
 rtl/fft_frame_reorder.sv | 220 ++++++++++++++++++++++
 tb/tb_fft_frame_reorder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_reorder.sv
// Ping-pong frame buffer that re-emits each FFT frame in natural or
// bit-reversed point order, two complex points per cycle, at full throughput.
module fft_frame_reorder #(
    parameter int DW    = 16,
    parameter int LOG2N = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          next,
    input  logic          bitrev,
    input  logic [DW-1:0] X0,
    input  logic [DW-1:0] X1,
    input  logic [DW-1:0] X2,
    input  logic [DW-1:0] X3,
    output logic          next_out,
    output logic [DW-1:0] Y0,
    output logic [DW-1:0] Y1,
    output logic [DW-1:0] Y2,
    output logic [DW-1:0] Y3,
    output logic          overrun
);
    localparam int HALF = 1 << (LOG2N - 1);
    localparam int AW   = LOG2N - 1;
    localparam int WW   = 2 * DW;
    localparam logic [AW-1:0] LAST = AW'(HALF - 1);
    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO = {AW{1'b0}};

    typedef enum logic {W_IDLE = 1'b0, W_FILL  = 1'b1} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_t;

    function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    function automatic logic bank_of(input logic [LOG2N-1:0] i);
        return i[0] ^ i[LOG2N-1];
    endfunction

    logic [WW-1:0] bank0_mem [2*HALF];
    logic [WW-1:0] bank1_mem [2*HALF];

    wstate_t       w_state_q, w_state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          wsel_q, wsel_d;
    logic [1:0]    mode_q, mode_d;
    logic          overrun_q, overrun_d;
    rstate_t       r_state_q, r_state_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic          rbuf_q, rbuf_d;
    logic          rmode_q, rmode_d;
    logic          rv_q, rv_d;
    logic          swap_q, swap_d;
    logic [WW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [WW-1:0] y01_q, y01_d, y23_q, y23_d;
    logic          next_out_q, next_out_d;

    logic             wr_last_s, wr_en_s;
    logic [WW-1:0]    wr0_s, wr1_s;
    logic             rd_en_s, rd_buf_s, rd_mode_s, bank_a_s;
    logic [AW-1:0]    rd_j_s, addr0_s, addr1_s;
    logic [LOG2N-1:0] pt_a_s, pt_b_s;

    assign wr_last_s = (w_state_q == W_FILL) && (wcnt_q == LAST);
    assign wr_en_s   = (w_state_q == W_FILL);

    // Write FSM: frame acceptance, fill counter, ping-pong select and overrun detection
    always_comb begin
        w_state_d = w_state_q;
        wcnt_d    = wcnt_q;
        wsel_d    = wsel_q;
        mode_d    = mode_q;
        overrun_d = overrun_q;
        case (w_state_q)
            W_IDLE: begin
                if (next) begin
                    mode_d[wsel_q] = bitrev;
                    wcnt_d         = ZERO;
                    w_state_d      = W_FILL;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_FILL: begin
                wcnt_d = wcnt_q + ONE;
                if (wr_last_s) begin
                    wsel_d = ~wsel_q;
                    if (next) begin
                        mode_d[~wsel_q] = bitrev;
                        wcnt_d          = ZERO;
                    end else begin
                        w_state_d = W_IDLE;
                    end
                end else if (next) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Input pair (2k, 2k+1) lands in opposite banks; the frame's top index bit decides which
    always_comb begin
        if (wcnt_q[AW-1]) begin
            wr0_s = {X2, X3};
            wr1_s = {X0, X1};
        end else begin
            wr0_s = {X0, X1};
            wr1_s = {X2, X3};
        end
    end

    // Read side: the first pair is fetched in the final write cycle so the output stays contiguous
    always_comb begin
        rd_en_s   = wr_last_s || (r_state_q == R_DRAIN);
        rd_j_s    = wr_last_s ? ZERO : rcnt_q;
        rd_buf_s  = wr_last_s ? wsel_q : rbuf_q;
        rd_mode_s = wr_last_s ? mode_q[wsel_q] : rmode_q;
        pt_a_s    = rd_mode_s ? rev({rd_j_s, 1'b0}) : {rd_j_s, 1'b0};
        pt_b_s    = rd_mode_s ? rev({rd_j_s, 1'b1}) : {rd_j_s, 1'b1};
        bank_a_s  = bank_of(pt_a_s);
        addr0_s   = bank_a_s ? pt_b_s[LOG2N-1:1] : pt_a_s[LOG2N-1:1];
        addr1_s   = bank_a_s ? pt_a_s[LOG2N-1:1] : pt_b_s[LOG2N-1:1];
        rd0_d     = bank0_mem[{rd_buf_s, addr0_s}];
        rd1_d     = bank1_mem[{rd_buf_s, addr1_s}];
        rv_d      = rd_en_s;
        swap_d    = bank_a_s;
        y01_d     = rv_q ? (swap_q ? rd1_q : rd0_q) : {WW{1'b0}};
        y23_d     = rv_q ? (swap_q ? rd0_q : rd1_q) : {WW{1'b0}};
        next_out_d = wr_last_s;
    end

    // Read FSM: drain counter for the buffer that just filled
    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rbuf_d    = rbuf_q;
        rmode_d   = rmode_q;
        if (wr_last_s) begin
            r_state_d = R_DRAIN;
            rcnt_d    = ONE;
            rbuf_d    = wsel_q;
            rmode_d   = mode_q[wsel_q];
        end else begin
            case (r_state_q)
                R_IDLE:  r_state_d = R_IDLE;
                R_DRAIN: begin
                    rcnt_d = rcnt_q + ONE;
                    if (rcnt_q == LAST) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_state_d = R_DRAIN;
                    end
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    // Frame storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            bank0_mem[{wsel_q, wcnt_q}] <= wr0_s;
            bank1_mem[{wsel_q, wcnt_q}] <= wr1_s;
        end
    end

    // Control, read-data and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q  <= W_IDLE;
            wcnt_q     <= ZERO;
            wsel_q     <= 1'b0;
            mode_q     <= 2'b00;
            overrun_q  <= 1'b0;
            r_state_q  <= R_IDLE;
            rcnt_q     <= ZERO;
            rbuf_q     <= 1'b0;
            rmode_q    <= 1'b0;
            rv_q       <= 1'b0;
            swap_q     <= 1'b0;
            rd0_q      <= {WW{1'b0}};
            rd1_q      <= {WW{1'b0}};
            y01_q      <= {WW{1'b0}};
            y23_q      <= {WW{1'b0}};
            next_out_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            wcnt_q     <= wcnt_d;
            wsel_q     <= wsel_d;
            mode_q     <= mode_d;
            overrun_q  <= overrun_d;
            r_state_q  <= r_state_d;
            rcnt_q     <= rcnt_d;
            rbuf_q     <= rbuf_d;
            rmode_q    <= rmode_d;
            rv_q       <= rv_d;
            swap_q     <= swap_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
            y01_q      <= y01_d;
            y23_q      <= y23_d;
            next_out_q <= next_out_d;
        end
    end

    assign next_out = next_out_q;
    assign overrun  = overrun_q;
    assign Y0       = y01_q[WW-1:DW];
    assign Y1       = y01_q[DW-1:0];
    assign Y2       = y23_q[WW-1:DW];
    assign Y3       = y23_q[DW-1:0];

endmodule

// File: tb/tb_fft_frame_reorder.sv
// Bench for fft_frame_reorder: a per-cycle timeline model (N=16 and N=1024 instances)
// plus a literal ordering table for the N=16 natural and bit-reversed frames.
module tb_fft_frame_reorder;
    localparam int MAXC = 4096;

    typedef struct {
        logic        mode;
        int          j;
        logic [15:0] y0;
        logic [15:0] y2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_next = 1'b0, s_bitrev = 1'b0, s_no, s_ovr;
    logic [15:0] s_x0 = 16'd0, s_x1 = 16'd0, s_x2 = 16'd0, s_x3 = 16'd0;
    logic [15:0] s_y0, s_y1, s_y2, s_y3;
    logic        b_next = 1'b0, b_bitrev = 1'b0, b_no, b_ovr;
    logic [23:0] b_x0 = 24'd0, b_x1 = 24'd0, b_x2 = 24'd0, b_x3 = 24'd0;
    logic [23:0] b_y0, b_y1, b_y2, b_y3;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int ovr_at = 1 << 30;

    logic        dn  [2][MAXC];
    logic        db  [2][MAXC];
    logic [23:0] dx  [2][4][MAXC];
    logic        eno [2][MAXC];
    logic [23:0] ex  [2][4][MAXC];
    logic        cno [MAXC];
    logic [15:0] cy  [4][MAXC];

    fft_frame_reorder #(.DW(16), .LOG2N(4)) u_small (
        .clk(clk), .reset(reset), .next(s_next), .bitrev(s_bitrev),
        .X0(s_x0), .X1(s_x1), .X2(s_x2), .X3(s_x3),
        .next_out(s_no), .Y0(s_y0), .Y1(s_y1), .Y2(s_y2), .Y3(s_y3), .overrun(s_ovr)
    );

    fft_frame_reorder #(.DW(24), .LOG2N(10)) u_big (
        .clk(clk), .reset(reset), .next(b_next), .bitrev(b_bitrev),
        .X0(b_x0), .X1(b_x1), .X2(b_x2), .X3(b_x3),
        .next_out(b_no), .Y0(b_y0), .Y1(b_y1), .Y2(b_y2), .Y3(b_y3), .overrun(b_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int brev(input int n, input int bits);
        int r = 0;
        int v = n;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int c, input logic [95:0] got, input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @%0d: got %h expected %h", nm, c, got, want);
        end
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            for (int d = 0; d < 2; d++) begin
                dn[d][c]  = 1'b0;
                db[d][c]  = 1'b0;
                eno[d][c] = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    dx[d][k][c] = 24'd0;
                    ex[d][k][c] = 24'd0;
                end
            end
        end
    endtask

    // Schedule one frame on instance d with `next` in cycle c, and its expected output timeline.
    task automatic plan_frame(input int d, input int c, input logic mode, input logic rnd, input int tag);
        int half = (d == 1) ? 512 : 8;
        int lg   = (d == 1) ? 10 : 4;
        int top  = (d == 1) ? 24'hFFFFFF : 24'h00FFFF;
        logic [23:0] re [1024];
        logic [23:0] im [1024];
        int a, b, o;
        for (int i = 0; i < 2 * half; i++) begin
            re[i] = rnd ? 24'($urandom_range(top, 0)) : 24'(i);
            im[i] = rnd ? 24'($urandom_range(top, 0)) : 24'(tag);
        end
        dn[d][c] = 1'b1;
        db[d][c] = mode;
        for (int k = 0; k < half; k++) begin
            dx[d][0][c+1+k] = re[2*k];
            dx[d][1][c+1+k] = im[2*k];
            dx[d][2][c+1+k] = re[2*k+1];
            dx[d][3][c+1+k] = im[2*k+1];
        end
        eno[d][c+half+1] = 1'b1;
        for (int j = 0; j < half; j++) begin
            o = c + half + 2 + j;
            a = mode ? brev(2*j, lg) : 2*j;
            b = mode ? brev(2*j+1, lg) : 2*j+1;
            ex[d][0][o] = re[a];
            ex[d][1][o] = im[a];
            ex[d][2][o] = re[b];
            ex[d][3][o] = im[b];
        end
    endtask

    // Each step: compare outputs of the current cycle, record them, then drive its inputs.
    task automatic run_cycles(input int n);
        int c;
        repeat (n) begin
            @(negedge clk);
            c = cyc;
            chk("s_next_out", c, {95'd0, s_no}, {95'd0, eno[0][c]});
            chk("s_data", c, {8'h00, s_y0, 8'h00, s_y1, 8'h00, s_y2, 8'h00, s_y3},
                {ex[0][0][c], ex[0][1][c], ex[0][2][c], ex[0][3][c]});
            chk("s_overrun", c, {95'd0, s_ovr}, {95'd0, (c >= ovr_at)});
            chk("b_next_out", c, {95'd0, b_no}, {95'd0, eno[1][c]});
            chk("b_data", c, {b_y0, b_y1, b_y2, b_y3},
                {ex[1][0][c], ex[1][1][c], ex[1][2][c], ex[1][3][c]});
            chk("b_overrun", c, {95'd0, b_ovr}, 96'd0);
            cno[c]   = s_no;
            cy[0][c] = s_y0;
            cy[1][c] = s_y1;
            cy[2][c] = s_y2;
            cy[3][c] = s_y3;
            s_next   = dn[0][c];
            s_bitrev = db[0][c];
            s_x0 = dx[0][0][c][15:0];
            s_x1 = dx[0][1][c][15:0];
            s_x2 = dx[0][2][c][15:0];
            s_x3 = dx[0][3][c][15:0];
            b_next   = dn[1][c];
            b_bitrev = db[1][c];
            b_x0 = dx[1][0][c];
            b_x1 = dx[1][1][c];
            b_x2 = dx[1][2][c];
            b_x3 = dx[1][3][c];
        end
    endtask

    initial begin
        vec_t tbl [16];
        int   rv0 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int   c_nat, c_rev, c0, base, pulses;

        clear_from(0);
        for (int j = 0; j < 8; j++) begin
            tbl[j].mode   = 1'b0;
            tbl[j].j      = j;
            tbl[j].y0     = 16'(2 * j);
            tbl[j].y2     = 16'(2 * j + 1);
            tbl[8+j].mode = 1'b1;
            tbl[8+j].j    = j;
            tbl[8+j].y0   = 16'(rv0[j]);
            tbl[8+j].y2   = 16'(rv0[j] + 8);
        end

        // reset state
        run_cycles(3);
        reset = 1'b0;

        // single natural and bit-reversed frames with the ramp pattern
        c_nat = cyc + 2;
        plan_frame(0, c_nat, 1'b0, 1'b0, 0);
        c_rev = c_nat + 20;
        plan_frame(0, c_rev, 1'b1, 1'b0, 0);
        run_cycles(45);
        for (int i = 0; i < 16; i++) begin
            base = tbl[i].mode ? c_rev : c_nat;
            chk("order_table", i, {64'd0, cy[0][base+10+tbl[i].j], cy[2][base+10+tbl[i].j]},
                {64'd0, tbl[i].y0, tbl[i].y2});
        end

        // four back-to-back frames, alternating mode, tag in the imaginary words
        c0 = cyc + 2;
        for (int f = 0; f < 4; f++) begin
            plan_frame(0, c0 + 8 * f, (f % 2 == 0) ? 1'b1 : 1'b0, 1'b0, f + 1);
        end
        run_cycles(55);
        pulses = 0;
        for (int c = c0; c < c0 + 50; c++) begin
            pulses += int'(cno[c]);
        end
        chk("b2b_pulse_count", c0, 96'(pulses), 96'd4);

        // stray next three cycles into a fill
        c0 = cyc + 2;
        plan_frame(0, c0, 1'b0, 1'b1, 0);
        dn[0][c0+3] = 1'b1;
        db[0][c0+3] = 1'b1;
        ovr_at = c0 + 4;
        run_cycles(30);

        // asynchronous reset during output pair j=3, then a clean frame
        c0 = cyc + 2;
        plan_frame(0, c0, 1'b1, 1'b1, 0);
        run_cycles(c0 + 13 - cyc);
        reset = 1'b1;
        #1;
        chk("reset_async", c0 + 13, {31'd0, s_no, s_y0, s_y1, s_y2, s_y3}, 96'd0);
        ovr_at = 1 << 30;
        clear_from(c0 + 14);
        run_cycles(1);
        reset = 1'b0;
        c0 = cyc + 2;
        plan_frame(0, c0, 1'b0, 1'b1, 0);
        run_cycles(25);

        // random frames, random modes and legal gaps
        c0 = cyc + 2;
        for (int f = 0; f < 6; f++) begin
            plan_frame(0, c0, 1'($urandom_range(1, 0)), 1'b1, 0);
            c0 += int'($urandom_range(12, 8));
        end
        run_cycles(c0 + 20 - cyc);

        // N=1024, DW=24, random data, bit-reversed
        c0 = cyc + 2;
        plan_frame(1, c0, 1'b1, 1'b1, 0);
        run_cycles(c0 + 1030 - cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
